tlk2711_rx_deframer: RTL and testbench

//  Receive-side counterpart of the TLK2711 transmit framer. Runs on the recovered
//  rx clock and consumes the 16-bit parallel word stream and K flags from the

---
 rtl/tlk2711_rx_deframer.sv | 222 ++++++++++++++++++++++
 tb/tb_tlk2711_rx_deframer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rx_deframer.sv
// Receive deframer for the TLK2711 link: delineates IDLE* SOF LEN D[] CSUM EOF frames,
// checks length and checksum, and streams the payload with per-frame status and counters.
module tlk2711_rx_deframer #(
   parameter int MAX_LEN    = 1024,
   parameter int SYNC_IDLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,
   input  logic [15:0] i_rxd,
   input  logic        i_rkmsb,
   input  logic        i_rklsb,
   output logic [15:0] o_data,
   output logic        o_valid,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_frame_ok,
   output logic        o_frame_err,
   output logic [2:0]  o_err_code,
   output logic        o_link_up,
   output logic [31:0] o_frame_cnt,
   output logic [15:0] o_err_cnt
);

   localparam int IDLE_W = $clog2(SYNC_IDLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SYNC_IDLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam logic [16:0]       MAX_LEN_W = 17'(MAX_LEN);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_CSUM, S_EOF} state_t;

   logic [15:0]       rxd_r;
   logic              kmsb_r, klsb_r, en_r;
   state_t            state_r, state_s;
   logic [15:0]       cnt_r, cnt_s, sum_r, sum_s;
   logic              first_r, first_s;
   logic              valid_s, sof_s, eof_s, ok_s, err_s;
   logic [2:0]        code_s;
   logic [IDLE_W-1:0] idle_cnt_r;
   logic [1:0]        k_s;
   logic              is_idle_s, is_sof_s, is_eof_s, is_data_s, is_badk_s;
   logic              link_clr_s, idle_run_s;

   assign k_s       = {kmsb_r, klsb_r};
   assign is_idle_s = (k_s == 2'b01) && (rxd_r == 16'h50BC);
   assign is_sof_s  = (k_s == 2'b11) && (rxd_r == 16'hFBFB);
   assign is_eof_s  = (k_s == 2'b11) && (rxd_r == 16'hFDFD);
   assign is_data_s = (k_s == 2'b00);
   assign is_badk_s = !is_data_s && !is_idle_s && !is_sof_s && !is_eof_s;

   // Input register: the enable travels with the word it qualifies.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_r  <= 16'd0;
         kmsb_r <= 1'b0;
         klsb_r <= 1'b0;
         en_r   <= 1'b0;
      end else begin
         rxd_r  <= i_rxd;
         kmsb_r <= i_rkmsb;
         klsb_r <= i_rklsb;
         en_r   <= i_enable;
      end
   end

   // Frame FSM next-state and per-word decisions.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      sum_s   = sum_r;
      first_s = first_r;
      valid_s = 1'b0;
      sof_s   = 1'b0;
      eof_s   = 1'b0;
      ok_s    = 1'b0;
      err_s   = 1'b0;
      code_s  = 3'd0;
      if (!en_r) begin
         state_s = S_IDLE;
      end else if (is_sof_s && (state_r != S_IDLE)) begin
         err_s   = 1'b1;
         code_s  = 3'd5;
         state_s = S_LEN;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (is_sof_s) state_s = S_LEN;
               else          state_s = S_IDLE;
            end
            S_LEN: begin
               if (is_data_s) begin
                  if ((rxd_r == 16'd0) || ({1'b0, rxd_r} > MAX_LEN_W)) begin
                     err_s   = 1'b1;
                     code_s  = 3'd1;
                     state_s = S_IDLE;
                  end else begin
                     cnt_s   = rxd_r;
                     sum_s   = rxd_r;
                     first_s = 1'b1;
                     state_s = S_PAY;
                  end
               end else begin
                  err_s   = 1'b1;
                  code_s  = 3'd2;
                  state_s = S_IDLE;
               end
            end
            S_PAY: begin
               if (is_data_s) begin
                  valid_s = 1'b1;
                  sof_s   = first_r;
                  first_s = 1'b0;
                  sum_s   = sum_r + rxd_r;
                  cnt_s   = cnt_r - 16'd1;
                  if (cnt_r == 16'd1) begin
                     eof_s   = 1'b1;
                     state_s = S_CSUM;
                  end else begin
                     state_s = S_PAY;
                  end
               end else begin
                  err_s   = 1'b1;
                  code_s  = 3'd2;
                  state_s = S_IDLE;
               end
            end
            S_CSUM: begin
               if (is_data_s) begin
                  if (rxd_r == sum_r) begin
                     state_s = S_EOF;
                  end else begin
                     err_s   = 1'b1;
                     code_s  = 3'd3;
                     state_s = S_IDLE;
                  end
               end else begin
                  err_s   = 1'b1;
                  code_s  = 3'd2;
                  state_s = S_IDLE;
               end
            end
            S_EOF: begin
               if (is_eof_s) begin
                  ok_s    = 1'b1;
                  state_s = S_IDLE;
               end else begin
                  err_s   = 1'b1;
                  code_s  = 3'd4;
                  state_s = S_IDLE;
               end
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end
   end

   // Frame FSM state, length down-counter and running checksum.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         cnt_r   <= 16'd0;
         sum_r   <= 16'd0;
         first_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         sum_r   <= sum_s;
         first_r <= first_s;
      end
   end

   // Sync is lost on framing-level K errors only; length/checksum/EOF errors keep it.
   assign link_clr_s = !en_r || is_badk_s ||
                       (err_s && ((code_s == 3'd2) || (code_s == 3'd5)));
   assign idle_run_s = (state_r == S_IDLE) && is_idle_s;

   // Link-up tracking from consecutive IDLE words between frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_link_up  <= 1'b0;
         idle_cnt_r <= '0;
      end else if (link_clr_s) begin
         o_link_up  <= 1'b0;
         idle_cnt_r <= '0;
      end else if (idle_run_s) begin
         if (idle_cnt_r == IDLE_LAST) o_link_up  <= 1'b1;
         else                         idle_cnt_r <= idle_cnt_r + IDLE_ONE;
      end else begin
         idle_cnt_r <= '0;
      end
   end

   // Output register: payload stream, status pulses and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_data      <= 16'd0;
         o_valid     <= 1'b0;
         o_sof       <= 1'b0;
         o_eof       <= 1'b0;
         o_frame_ok  <= 1'b0;
         o_frame_err <= 1'b0;
         o_err_code  <= 3'd0;
         o_frame_cnt <= 32'd0;
         o_err_cnt   <= 16'd0;
      end else begin
         o_valid     <= valid_s;
         o_sof       <= sof_s;
         o_eof       <= eof_s;
         o_frame_ok  <= ok_s;
         o_frame_err <= err_s;
         if (valid_s) o_data <= rxd_r;
         if (ok_s)    o_frame_cnt <= o_frame_cnt + 32'd1;
         if (err_s) begin
            o_err_code <= code_s;
            if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// Directed bench for tlk2711_rx_deframer: payload words are scoreboarded with their due cycle,
// frame status and counters are checked after each scenario.
module tb_tlk2711_rx_deframer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_enable = 1'b1;
   logic [15:0] i_rxd = 16'h50BC;
   logic        i_rkmsb = 1'b0;
   logic        i_rklsb = 1'b1;
   logic [15:0] o_data;
   logic        o_valid, o_sof, o_eof, o_frame_ok, o_frame_err, o_link_up;
   logic [2:0]  o_err_code;
   logic [31:0] o_frame_cnt;
   logic [15:0] o_err_cnt;

   typedef struct {
      int          due;
      logic [15:0] d;
      logic        s;
      logic        e;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ok_n  = 0;
   int   err_n = 0;
   bit   rst_v = 1'b1;
   bit   en_v  = 1'b1;

   always #5 clk = ~clk;

   tlk2711_rx_deframer #(.MAX_LEN(1024), .SYNC_IDLES(4)) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_rxd(i_rxd),
      .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb), .o_data(o_data), .o_valid(o_valid),
      .o_sof(o_sof), .o_eof(o_eof), .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err),
      .o_err_code(o_err_code), .o_link_up(o_link_up), .o_frame_cnt(o_frame_cnt),
      .o_err_cnt(o_err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One word per clock: observe outputs on the falling edge, then drive the next word.
   task automatic tick(input logic km, input logic kl, input logic [15:0] d,
                       input bit push, input bit s, input bit e);
      exp_t x;
      @(negedge clk);
      cyc++;
      if (o_frame_ok === 1'b1 || o_frame_err === 1'b1)
         chk("pulse_exclusive", {31'd0, o_frame_ok & o_frame_err}, 32'd0);
      if (o_frame_ok === 1'b1)  ok_n++;
      if (o_frame_err === 1'b1) err_n++;
      while (q.size() > 0 && q[0].due < cyc) begin
         chk("missing_word_due", 32'(cyc), 32'(q[0].due));
         void'(q.pop_front());
      end
      if (o_valid === 1'b1) begin
         chk("valid_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("data",    {16'd0, o_data}, {16'd0, x.d});
            chk("sof",     {31'd0, o_sof},  {31'd0, x.s});
            chk("eof",     {31'd0, o_eof},  {31'd0, x.e});
            chk("latency", 32'(cyc),        32'(x.due));
         end
      end
      rst      = rst_v;
      i_enable = en_v;
      i_rkmsb  = km;
      i_rklsb  = kl;
      i_rxd    = d;
      if (push) q.push_back('{cyc + 2, d, s, e});
   endtask

   task automatic idle_w(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 16'h50BC, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sof_w();
      tick(1'b1, 1'b1, 16'hFBFB, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic eof_w();
      tick(1'b1, 1'b1, 16'hFDFD, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic dw(input logic [15:0] d, input bit push, input bit s, input bit e);
      tick(1'b0, 1'b0, d, push, s, e);
   endtask

   task automatic good_frame(input int len, input logic [15:0] base);
      logic [15:0] sum;
      logic [15:0] d;
      sum = 16'(len);
      sof_w();
      dw(16'(len), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
         d   = base + 16'(i * 3);
         sum = sum + d;
         dw(d, 1'b1, i == 0, i == len - 1);
      end
      dw(sum, 1'b0, 1'b0, 1'b0);
      eof_w();
   endtask

   initial begin
      // reset state
      rst_v = 1'b1;
      idle_w(3);
      chk("rst_valid",     {31'd0, o_valid},     32'd0);
      chk("rst_link",      {31'd0, o_link_up},   32'd0);
      chk("rst_err_code",  {29'd0, o_err_code},  32'd0);
      chk("rst_frame_cnt", o_frame_cnt,          32'd0);
      chk("rst_err_cnt",   {16'd0, o_err_cnt},   32'd0);
      rst_v = 1'b0;

      // 1: sync then a good LEN=3 frame
      idle_w(4);
      sof_w();
      dw(16'd3, 1'b0, 1'b0, 1'b0);
      dw(16'h1111, 1'b1, 1'b1, 1'b0);
      dw(16'h2222, 1'b1, 1'b0, 1'b0);
      dw(16'h3333, 1'b1, 1'b0, 1'b1);
      dw(16'h6669, 1'b0, 1'b0, 1'b0);
      eof_w();
      idle_w(3);
      chk("t1_link",      {31'd0, o_link_up}, 32'd1);
      chk("t1_ok_pulses", 32'(ok_n),          32'd1);
      chk("t1_err_pulses",32'(err_n),         32'd0);
      chk("t1_frame_cnt", o_frame_cnt,        32'd1);

      // 2: checksum mismatch
      sof_w();
      dw(16'd3, 1'b0, 1'b0, 1'b0);
      dw(16'h1111, 1'b1, 1'b1, 1'b0);
      dw(16'h2222, 1'b1, 1'b0, 1'b0);
      dw(16'h3333, 1'b1, 1'b0, 1'b1);
      dw(16'h0000, 1'b0, 1'b0, 1'b0);
      eof_w();
      idle_w(3);
      chk("t2_err_pulses",32'(err_n),          32'd1);
      chk("t2_err_code",  {29'd0, o_err_code}, 32'd3);
      chk("t2_err_cnt",   {16'd0, o_err_cnt},  32'd1);
      chk("t2_frame_cnt", o_frame_cnt,         32'd1);
      chk("t2_link",      {31'd0, o_link_up},  32'd1);

      // 3: LEN bounds
      sof_w();
      dw(16'd0, 1'b0, 1'b0, 1'b0);
      idle_w(3);
      chk("t3_len0_code", {29'd0, o_err_code}, 32'd1);
      chk("t3_len0_cnt",  {16'd0, o_err_cnt},  32'd2);
      sof_w();
      dw(16'd1025, 1'b0, 1'b0, 1'b0);
      idle_w(3);
      chk("t3_lenbig_cnt",  {16'd0, o_err_cnt},  32'd3);
      chk("t3_lenbig_code", {29'd0, o_err_code}, 32'd1);
      good_frame(1024, 16'h0100);
      idle_w(3);
      chk("t3_max_ok",        32'(ok_n),   32'd2);
      chk("t3_max_frame_cnt", o_frame_cnt, 32'd2);
      chk("t3_link",          {31'd0, o_link_up}, 32'd1);

      // 4: SOF mid-payload, then LEN=1 frame
      sof_w();
      dw(16'd5, 1'b0, 1'b0, 1'b0);
      dw(16'hA001, 1'b1, 1'b1, 1'b0);
      dw(16'hA002, 1'b1, 1'b0, 1'b0);
      sof_w();
      dw(16'd1, 1'b0, 1'b0, 1'b0);
      dw(16'hABCD, 1'b1, 1'b1, 1'b1);
      dw(16'hABCE, 1'b0, 1'b0, 1'b0);
      eof_w();
      idle_w(3);
      chk("t4_err_pulses", 32'(err_n),          32'd4);
      chk("t4_err_code",   {29'd0, o_err_code}, 32'd5);
      chk("t4_err_cnt",    {16'd0, o_err_cnt},  32'd4);
      chk("t4_ok_pulses",  32'(ok_n),           32'd3);
      chk("t4_frame_cnt",  o_frame_cnt,         32'd3);
      chk("t4_link",       {31'd0, o_link_up},  32'd0);

      // 5: checksum wrap, missing EOF, unexpected IDLE
      idle_w(4);
      chk("t5_resync", {31'd0, o_link_up}, 32'd1);
      sof_w();
      dw(16'd2, 1'b0, 1'b0, 1'b0);
      dw(16'hFFFF, 1'b1, 1'b1, 1'b0);
      dw(16'hFFFF, 1'b1, 1'b0, 1'b1);
      dw(16'h0000, 1'b0, 1'b0, 1'b0);
      eof_w();
      idle_w(3);
      chk("t5_wrap_ok",    32'(ok_n),   32'd4);
      chk("t5_frame_cnt",  o_frame_cnt, 32'd4);
      sof_w();
      dw(16'd1, 1'b0, 1'b0, 1'b0);
      dw(16'h0005, 1'b1, 1'b1, 1'b1);
      dw(16'h0006, 1'b0, 1'b0, 1'b0);
      dw(16'h1234, 1'b0, 1'b0, 1'b0);
      idle_w(3);
      chk("t5_noeof_code", {29'd0, o_err_code}, 32'd4);
      chk("t5_noeof_cnt",  {16'd0, o_err_cnt},  32'd5);
      chk("t5_noeof_link", {31'd0, o_link_up},  32'd1);
      sof_w();
      dw(16'd3, 1'b0, 1'b0, 1'b0);
      dw(16'h7777, 1'b1, 1'b1, 1'b0);
      idle_w(3);
      chk("t5_k_code", {29'd0, o_err_code}, 32'd2);
      chk("t5_k_cnt",  {16'd0, o_err_cnt},  32'd6);
      chk("t5_k_link", {31'd0, o_link_up},  32'd0);

      // 6: enable drop mid-payload, then reset mid-frame
      idle_w(4);
      chk("t6_resync", {31'd0, o_link_up}, 32'd1);
      sof_w();
      dw(16'd4, 1'b0, 1'b0, 1'b0);
      dw(16'hB001, 1'b1, 1'b1, 1'b0);
      dw(16'hB002, 1'b1, 1'b0, 1'b0);
      en_v = 1'b0;
      dw(16'hB003, 1'b0, 1'b0, 1'b0);
      idle_w(3);
      en_v = 1'b1;
      dw(16'hB004, 1'b0, 1'b0, 1'b0);
      idle_w(3);
      chk("t6_en_link",      {31'd0, o_link_up}, 32'd0);
      chk("t6_en_err_pulse", 32'(err_n),         32'd6);
      chk("t6_en_ok_pulse",  32'(ok_n),          32'd4);
      chk("t6_en_err_cnt",   {16'd0, o_err_cnt}, 32'd6);
      chk("t6_en_frame_cnt", o_frame_cnt,        32'd4);
      sof_w();
      dw(16'd4, 1'b0, 1'b0, 1'b0);
      dw(16'hC001, 1'b1, 1'b1, 1'b0);
      dw(16'hC002, 1'b0, 1'b0, 1'b0);
      rst_v = 1'b1;
      idle_w(3);
      rst_v = 1'b0;
      idle_w(1);
      chk("t6_rst_err_pulse", 32'(err_n),          32'd6);
      chk("t6_rst_ok_pulse",  32'(ok_n),           32'd4);
      chk("t6_rst_frame_cnt", o_frame_cnt,         32'd0);
      chk("t6_rst_err_cnt",   {16'd0, o_err_cnt},  32'd0);
      chk("t6_rst_code",      {29'd0, o_err_code}, 32'd0);
      idle_w(4);
      good_frame(4, 16'h1000);
      idle_w(3);
      chk("t6_after_ok",   32'(ok_n),          32'd5);
      chk("t6_after_cnt",  o_frame_cnt,        32'd1);
      chk("t6_after_link", {31'd0, o_link_up}, 32'd1);
      chk("t6_after_err",  32'(err_n),         32'd6);

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
